sccb_responder: RTL

SCCB/I2C-style target that sits on the camera configuration bus and answers the register-write transactions our OV7670 configuration master issues. It decodes 3-phase writes (ID, sub-address, data) and 2-phase reads (ID, data), and presents them as a simple register-file port. It serves two purposes:
- as an in-FPGA camera register model for bring-up and simulation;
- as a config target for downstream blocks.

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_bus_monitor.sv | 54 +++++
 rtl/sccb_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-file target.
package sccb_pkg;

  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [7:0] OV7670_ID_W = 8'h42;
  localparam logic [7:0] OV7670_ID_R = 8'h43;

  typedef enum logic [3:0] {
    IDLE,
    ID_BYTE,
    ID_ACK_W,
    ID_ACK_R,
    SUB_BYTE,
    SUB_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_NA,
    IGNORE
  } sccb_state_t;

endpackage

// File: rtl/sccb_bus_monitor.sv
// Synchronises SIOC/SIOD and emits single-cycle edge and START/STOP pulses.
module sccb_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sioc,
  input  logic siod_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [SYNC_STAGES-1:0] sioc_sync;
  logic [SYNC_STAGES-1:0] siod_sync;
  logic                   sioc_hist;
  logic                   siod_hist;
  logic                   sioc_s;
  logic                   siod_s;
  logic                   scl_high;

  assign sioc_s   = sioc_sync[SYNC_STAGES-1];
  assign siod_s   = siod_sync[SYNC_STAGES-1];
  // START/STOP only count while SIOC was high on both samples, so a data
  // change racing a clock edge is never mistaken for a bus condition.
  assign scl_high = sioc_s & sioc_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_hist <= 1'b1;
      siod_hist <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      sda       <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_in};
      sioc_hist <= sioc_s;
      siod_hist <= siod_s;
      scl_rise  <= sioc_s & ~sioc_hist;
      scl_fall  <= ~sioc_s & sioc_hist;
      start     <= scl_high & siod_hist & ~siod_s;
      stop      <= scl_high & ~siod_hist & siod_s;
      sda       <= siod_s;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes ID/sub-address/data writes and ID/data reads into a register-file port.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID      = OV7670_ID_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       err_nack
);

  logic scl_rise, scl_fall, start, stop, sda;

  sccb_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .sioc     (sioc),
    .siod_in  (siod_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda      (sda)
  );

  sccb_state_t          state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [7:0]           rd_addr_nxt, wr_addr_nxt, wr_data_nxt;
  logic                 siod_oe_nxt, wr_en_nxt, busy_nxt, err_nack_nxt;
  logic [7:0]           byte_in;
  logic                 last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      siod_oe  <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      err_nack <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      rd_addr  <= rd_addr_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      siod_oe  <= siod_oe_nxt;
      wr_en    <= wr_en_nxt;
      busy     <= busy_nxt;
      err_nack <= err_nack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    rd_addr_nxt  = rd_addr;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    siod_oe_nxt  = siod_oe;
    busy_nxt     = busy;
    wr_en_nxt    = 1'b0;
    err_nack_nxt = 1'b0;
    byte_in      = {shift[6:0], sda};
    last_bit     = (bit_cnt == BIT_CNT_W'(7));

    if (stop) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      siod_oe_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start) begin
      state_nxt   = ID_BYTE;
      bit_cnt_nxt = '0;
      siod_oe_nxt = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      case (state)
        ID_BYTE, SUB_BYTE, WR_BYTE: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (last_bit) begin
              if (state == ID_BYTE) begin
                if (byte_in[7:1] == DEV_ID[7:1]) begin
                  state_nxt = byte_in[0] ? ID_ACK_R : ID_ACK_W;
                end else begin
                  err_nack_nxt = 1'b1;
                  state_nxt    = IGNORE;
                end
              end else if (state == SUB_BYTE) begin
                rd_addr_nxt = byte_in;
                state_nxt   = SUB_ACK;
              end else begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = rd_addr;
                wr_data_nxt = byte_in;
                state_nxt   = WR_ACK;
              end
            end
          end
        end
        // First fall after the 8th bit asserts ACK; the next fall ends it.
        ID_ACK_W, ID_ACK_R, SUB_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!siod_oe) begin
              siod_oe_nxt = 1'b1;
            end else begin
              siod_oe_nxt = 1'b0;
              bit_cnt_nxt = '0;
              case (state)
                ID_ACK_W: state_nxt = SUB_BYTE;
                SUB_ACK:  state_nxt = WR_BYTE;
                WR_ACK: begin
                  rd_addr_nxt = rd_addr + 8'd1;
                  state_nxt   = WR_BYTE;
                end
                default: begin
                  shift_nxt   = rd_data;
                  siod_oe_nxt = ~rd_data[7];
                  state_nxt   = RD_BYTE;
                end
              endcase
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt == '0) begin
              shift_nxt   = rd_data;
              siod_oe_nxt = ~rd_data[7];
            end else if (bit_cnt == BIT_CNT_W'(8)) begin
              siod_oe_nxt = 1'b0;
              state_nxt   = RD_NA;
            end else begin
              shift_nxt   = {shift[6:0], 1'b1};
              siod_oe_nxt = ~shift[6];
            end
          end
        end
        RD_NA: begin
          if (scl_rise) begin
            if (sda) begin
              state_nxt = IGNORE;
            end else begin
              err_nack_nxt = 1'b1;
              rd_addr_nxt  = rd_addr + 8'd1;
              bit_cnt_nxt  = '0;
              state_nxt    = RD_BYTE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
